rgb_timing_gen: RTL and testbench
=================================

Name: rgb_timing_gen

Overview:
- Initiator side of the panel pixel interface. Generates RGB raster timing (hsync, vsync, de) for the 750x1334 iPhone 7 LCD behind the SSD2828 bridge.
- Drives pixel_request, pixel_x, pixel_y, max_x and max_y to the pixel-pattern generator. That generator returns a registered pixel_data word, which is valid on the same cycle as de.
- Sits between the pclk domain root and the SSD2828 RGB input.

Parameters:
- H_ACT, 750, active pixels per line
- H_SW, 8, hsync width (pclk)
- H_BP, 40, horizontal back porch
- H_FP, 40, horizontal front porch
- V_ACT, 1334, active lines per frame
- V_SW, 2, vsync width (lines)
- V_BP, 8, vertical back porch
- V_FP, 8, vertical front porch
- HS_POL, 0, hsync active level
- VS_POL, 0, vsync active level
- CNT_W, 12, h/v counter width

Ports:
- pclk  in  1  pixel clock; single clock domain
- rst  in  1  synchronous, active-high reset
- run  in  1  enable raster generation
- hsync  out  1  horizontal sync, polarity set by HS_POL
- vsync  out  1  vertical sync, polarity set by VS_POL
- de  out  1  data enable, active high
- pixel_request  out  1  asks for the next pixel; leads de by 1 cycle
- pixel_x  out  11  column of requested pixel
- pixel_y  out  11  row of requested pixel
- max_x  out  11  constant H_ACT
- max_y  out  11  constant V_ACT
- frame_start  out  1  1-cycle pulse at position (0,0)
- frame_done  out  1  1-cycle pulse at the last position of a frame
- busy  out  1  high in RUN or DRAIN

Behaviour:
- One clock, pclk. Reset is synchronous and active-high on rst.
- Reset values:
  - state IDLE; h=0, v=0
  - hsync = ~HS_POL, vsync = ~VS_POL
  - de, pixel_request, frame_start, frame_done, busy = 0
  - pixel_x = pixel_y = 0
  - max_x/max_y hold their constants at all times.
- Derived constants: HT = H_SW+H_BP+H_ACT+H_FP (default 838); VT = V_SW+V_BP+V_ACT+V_FP (default 1352); HS = H_SW+H_BP; VS = V_SW+V_BP.
- All outputs are registered and describe the current position (h,v).
- FSM IDLE / RUN / DRAIN:
  - IDLE: run sampled high -> RUN. The next cycle is position (0,0) with frame_start=1.
  - RUN: h counts 0..HT-1 and wraps; on each wrap v increments, and v wraps at VT-1. Back-to-back frames have no gap. run low -> DRAIN.
  - DRAIN: raster continues. run high again -> RUN with no disturbance. At the last position (HT-1,VT-1) -> IDLE, and the next cycle shows idle outputs.
  - IDLE outputs: syncs inactive, de=0, pixel_request=0, h=v=0.
- Sync and data timing:
  - hsync active for h<H_SW on every line of RUN/DRAIN.
  - vsync active for all h on lines v<V_SW.
  - de=1 for HS<=h<HS+H_ACT and VS<=v<VS+V_ACT.
  - pixel_request=1 for HS-1<=h<HS+H_ACT-1 on active lines. On those cycles pixel_x = h-HS+1 (0..H_ACT-1) and pixel_y = v-VS (0..V_ACT-1). Otherwise pixel_x = pixel_y = 0.
  - Consequence: a responder that registers pixel_data on pixel_request aligns its data with de.
- Pulses:
  - frame_done=1 at (HT-1,VT-1) in RUN or DRAIN.
  - frame_start=1 at (0,0), including after a wrap in RUN.
- rst mid-frame: next cycle shows reset values. No partial-frame completion, no pulses.
- Width rules:
  - HT and VT must fit in CNT_W; H_ACT and V_ACT must be <=2047.
  - H_SW>=1, so HS>=1 and the request lead never crosses a line boundary.

Decomposition:
- Package rgb_timing_pkg holds:
  - default panel timing constants (750x1334 set) and a small simulation set
  - FSM state typedef (IDLE, RUN, DRAIN)
  - HT/VT/HS/VS derivation functions
- One natural sub-module, timing_axis: a wrap counter with enable and terminal-count output plus sync/active region decode. It is instantiated once for h and once for v; v is enabled by h terminal count.

Test Plan:
All scenarios use the sim set H_ACT=4, H_SW=1, H_BP=2, H_FP=1, V_ACT=3, V_SW=1, V_BP=1, V_FP=1. This gives HT=8, VT=6, HS=3, VS=2.
1. Reset, then run=1 at cycle 0 -> cycle 1: frame_start=1, hsync and vsync active, de=0. busy stays 1.
2. Continuous run -> first pixel_request at cycle 19 (v=2, h=2) with pixel_x=0, pixel_y=0. de=1 at cycles 20..23; request at 19..22 with pixel_x 0,1,2,3. Exactly 12 de cycles per frame.
3. Continuous run -> frame_done at cycle 48 and frame_start at cycle 49. hsync low 1 cycle every 8; vsync low for cycles 1..8.
4. run dropped at cycle 30 -> raster continues to frame_done at cycle 48; cycle 49 idle (busy=0, de=0, syncs inactive). run re-raised at cycle 35 instead -> uninterrupted second frame_start at 49.
5. rst=1 at cycle 22 (de active) -> cycle 23 shows all reset values. Release with run=1 -> frame_start one cycle after first run sample.
6. Default parameters, full frame -> 1334 lines of 750 de cycles each, frame period 838*1352 = 1,132,976 pclk. max_x=750, max_y=1334 constant.

Source files
------------

// File: rtl/rgb_timing_pkg.sv
// Shared definitions for the RGB raster timing generator.
// Holds the panel timing sets (750x1334 LCD and a tiny simulation raster),
// the controller state type and helpers that derive line/frame totals and
// the offset of the first active pixel/line.
package rgb_timing_pkg;

  // 750x1334 panel behind the SSD2828 bridge
  localparam int unsigned DefHAct = 750;
  localparam int unsigned DefHSw  = 8;
  localparam int unsigned DefHBp  = 40;
  localparam int unsigned DefHFp  = 40;
  localparam int unsigned DefVAct = 1334;
  localparam int unsigned DefVSw  = 2;
  localparam int unsigned DefVBp  = 8;
  localparam int unsigned DefVFp  = 8;

  // Small raster for simulation: HT=8, VT=6, HS=3, VS=2
  localparam int unsigned SimHAct = 4;
  localparam int unsigned SimHSw  = 1;
  localparam int unsigned SimHBp  = 2;
  localparam int unsigned SimHFp  = 1;
  localparam int unsigned SimVAct = 3;
  localparam int unsigned SimVSw  = 1;
  localparam int unsigned SimVBp  = 1;
  localparam int unsigned SimVFp  = 1;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StDrain = 2'd2
  } state_e;

  // Total positions per line/frame
  function automatic int unsigned calc_total(input int unsigned sw, input int unsigned bp,
                                             input int unsigned act, input int unsigned fp);
    return sw + bp + act + fp;
  endfunction

  // Index of the first active pixel/line
  function automatic int unsigned calc_start(input int unsigned sw, input int unsigned bp);
    return sw + bp;
  endfunction

endpackage

// File: rtl/timing_axis.sv
// One raster axis: a wrapping position counter plus region decode.
// The decode outputs describe the *next* count so the parent can register
// them alongside its state and keep every output flop-driven.
//   clk_i, rst_i  : clock, synchronous active-high reset
//   clr_i         : force the count to zero (idle)
//   en_i          : advance the count, wrapping at Total-1
//   tc_o          : current count is the terminal count
//   nxt_sync_o    : next count inside the sync pulse
//   nxt_act_o     : next count inside the active region
//   nxt_req_o     : next count inside the active region shifted early by Lead
//   nxt_ofs_o     : next count relative to the request region start, 0 outside
//   nxt_first_o   : next count is zero
//   nxt_last_o    : next count is the terminal count
module timing_axis #(
  parameter int unsigned Total    = 8,
  parameter int unsigned SyncW    = 1,
  parameter int unsigned ActStart = 3,
  parameter int unsigned ActLen   = 4,
  parameter int unsigned Lead     = 1,
  parameter int unsigned CntW     = 12
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clr_i,
  input  logic        en_i,
  output logic        tc_o,
  output logic        nxt_sync_o,
  output logic        nxt_act_o,
  output logic        nxt_req_o,
  output logic [10:0] nxt_ofs_o,
  output logic        nxt_first_o,
  output logic        nxt_last_o
);

  localparam logic [CntW-1:0] LastC = CntW'(Total - 1);
  localparam logic [CntW-1:0] SyncC = CntW'(SyncW);
  localparam logic [CntW-1:0] ActLo = CntW'(ActStart);
  localparam logic [CntW-1:0] ActHi = CntW'(ActStart + ActLen);
  localparam logic [CntW-1:0] ReqLo = CntW'(ActStart - Lead);
  localparam logic [CntW-1:0] ReqHi = CntW'(ActStart + ActLen - Lead);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign tc_o = (cnt_q == LastC);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = tc_o ? '0 : cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign nxt_sync_o  = (cnt_d < SyncC);
  assign nxt_act_o   = (cnt_d >= ActLo) && (cnt_d < ActHi);
  assign nxt_req_o   = (cnt_d >= ReqLo) && (cnt_d < ReqHi);
  assign nxt_ofs_o   = nxt_req_o ? 11'(cnt_d - ReqLo) : 11'd0;
  assign nxt_first_o = (cnt_d == '0);
  assign nxt_last_o  = (cnt_d == LastC);

endmodule

// File: rtl/rgb_timing_gen.sv
// RGB raster timing generator for the SSD2828 RGB input (pclk domain).
// Produces hsync/vsync/de plus a pixel request that leads de by one cycle,
// so a pattern source registering its data on pixel_request lines up with de.
//   pclk_i, rst_i, run_i        : clock, sync active-high reset, enable
//   hsync_o, vsync_o, de_o      : raster timing (sync polarity by parameter)
//   pixel_request_o, pixel_x_o,
//   pixel_y_o                   : request and coordinate of the next pixel
//   max_x_o, max_y_o            : active width/height constants
//   frame_start_o, frame_done_o : pulses at the first/last raster position
//   busy_o                      : raster running (RUN or DRAIN)
// All outputs are registered and describe the current raster position.
module rgb_timing_gen
  import rgb_timing_pkg::*;
#(
  parameter int unsigned H_ACT  = DefHAct,
  parameter int unsigned H_SW   = DefHSw,
  parameter int unsigned H_BP   = DefHBp,
  parameter int unsigned H_FP   = DefHFp,
  parameter int unsigned V_ACT  = DefVAct,
  parameter int unsigned V_SW   = DefVSw,
  parameter int unsigned V_BP   = DefVBp,
  parameter int unsigned V_FP   = DefVFp,
  parameter bit          HS_POL = 1'b0,
  parameter bit          VS_POL = 1'b0,
  parameter int unsigned CNT_W  = 12
) (
  input  logic        pclk_i,
  input  logic        rst_i,
  input  logic        run_i,
  output logic        hsync_o,
  output logic        vsync_o,
  output logic        de_o,
  output logic        pixel_request_o,
  output logic [10:0] pixel_x_o,
  output logic [10:0] pixel_y_o,
  output logic [10:0] max_x_o,
  output logic [10:0] max_y_o,
  output logic        frame_start_o,
  output logic        frame_done_o,
  output logic        busy_o
);

  localparam int unsigned HT = calc_total(H_SW, H_BP, H_ACT, H_FP);
  localparam int unsigned VT = calc_total(V_SW, V_BP, V_ACT, V_FP);
  localparam int unsigned HS = calc_start(H_SW, H_BP);
  localparam int unsigned VS = calc_start(V_SW, V_BP);

  state_e state_q, state_d;

  logic        h_clr, h_en, h_tc, v_en, v_tc, frame_last, act_d;
  logic        h_nxt_sync, h_nxt_act, h_nxt_req, h_nxt_first, h_nxt_last;
  logic        v_nxt_sync, v_nxt_act, v_nxt_req, v_nxt_first, v_nxt_last;
  logic [10:0] h_nxt_ofs, v_nxt_ofs;
  logic        req_d;

  assign frame_last = h_tc & v_tc;
  assign v_en       = h_en & h_tc;
  assign act_d      = (state_d != StIdle);

  always_comb begin
    state_d = state_q;
    h_clr   = 1'b0;
    h_en    = 1'b0;
    unique case (state_q)
      StIdle: begin
        // Hold (0,0) so the first RUN cycle shows the frame origin
        h_clr = 1'b1;
        if (run_i) state_d = StRun;
      end
      StRun: begin
        h_en = 1'b1;
        if (!run_i) state_d = StDrain;
      end
      StDrain: begin
        if (run_i) begin
          state_d = StRun;
          h_en    = 1'b1;
        end else if (frame_last) begin
          state_d = StIdle;
          h_clr   = 1'b1;
        end else begin
          h_en = 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
        h_clr   = 1'b1;
      end
    endcase
  end

  timing_axis #(
    .Total    (HT),
    .SyncW    (H_SW),
    .ActStart (HS),
    .ActLen   (H_ACT),
    .Lead     (1),
    .CntW     (CNT_W)
  ) u_h_axis (
    .clk_i       (pclk_i),
    .rst_i       (rst_i),
    .clr_i       (h_clr),
    .en_i        (h_en),
    .tc_o        (h_tc),
    .nxt_sync_o  (h_nxt_sync),
    .nxt_act_o   (h_nxt_act),
    .nxt_req_o   (h_nxt_req),
    .nxt_ofs_o   (h_nxt_ofs),
    .nxt_first_o (h_nxt_first),
    .nxt_last_o  (h_nxt_last)
  );

  timing_axis #(
    .Total    (VT),
    .SyncW    (V_SW),
    .ActStart (VS),
    .ActLen   (V_ACT),
    .Lead     (0),
    .CntW     (CNT_W)
  ) u_v_axis (
    .clk_i       (pclk_i),
    .rst_i       (rst_i),
    .clr_i       (h_clr),
    .en_i        (v_en),
    .tc_o        (v_tc),
    .nxt_sync_o  (v_nxt_sync),
    .nxt_act_o   (v_nxt_act),
    .nxt_req_o   (v_nxt_req),
    .nxt_ofs_o   (v_nxt_ofs),
    .nxt_first_o (v_nxt_first),
    .nxt_last_o  (v_nxt_last)
  );

  assign req_d = act_d & h_nxt_req & v_nxt_req;

  always_ff @(posedge pclk_i) begin
    if (rst_i) begin
      state_q         <= StIdle;
      hsync_o         <= ~HS_POL;
      vsync_o         <= ~VS_POL;
      de_o            <= 1'b0;
      pixel_request_o <= 1'b0;
      pixel_x_o       <= '0;
      pixel_y_o       <= '0;
      frame_start_o   <= 1'b0;
      frame_done_o    <= 1'b0;
      busy_o          <= 1'b0;
    end else begin
      state_q         <= state_d;
      hsync_o         <= (act_d && h_nxt_sync) ? HS_POL : ~HS_POL;
      vsync_o         <= (act_d && v_nxt_sync) ? VS_POL : ~VS_POL;
      de_o            <= act_d & h_nxt_act & v_nxt_act;
      pixel_request_o <= req_d;
      pixel_x_o       <= req_d ? h_nxt_ofs : 11'd0;
      pixel_y_o       <= req_d ? v_nxt_ofs : 11'd0;
      frame_start_o   <= act_d & h_nxt_first & v_nxt_first;
      frame_done_o    <= act_d & h_nxt_last & v_nxt_last;
      busy_o          <= act_d;
    end
  end

  assign max_x_o = 11'(H_ACT);
  assign max_y_o = 11'(V_ACT);

endmodule

// File: tb/tb_rgb_timing_gen.sv
// Directed bench for rgb_timing_gen on the 8x6 simulation raster, with a
// second default-timing instance checked for its constants and early syncs.
module tb_rgb_timing_gen;
  import rgb_timing_pkg::*;

  localparam int NCyc = 64;

  logic pclk = 1'b0;
  logic rst  = 1'b1;
  logic run  = 1'b0;

  logic        hsync, vsync, de, preq, fs, fd, busy;
  logic [10:0] px, py, max_x, max_y;
  logic        d_hsync, d_vsync, d_de, d_preq, d_fs, d_fd, d_busy;
  logic [10:0] d_px, d_py, d_max_x, d_max_y;

  always #5 pclk = ~pclk;

  rgb_timing_gen #(
    .H_ACT (SimHAct), .H_SW (SimHSw), .H_BP (SimHBp), .H_FP (SimHFp),
    .V_ACT (SimVAct), .V_SW (SimVSw), .V_BP (SimVBp), .V_FP (SimVFp),
    .HS_POL (1'b0), .VS_POL (1'b0), .CNT_W (12)
  ) u_dut (
    .pclk_i (pclk), .rst_i (rst), .run_i (run),
    .hsync_o (hsync), .vsync_o (vsync), .de_o (de), .pixel_request_o (preq),
    .pixel_x_o (px), .pixel_y_o (py), .max_x_o (max_x), .max_y_o (max_y),
    .frame_start_o (fs), .frame_done_o (fd), .busy_o (busy)
  );

  rgb_timing_gen u_dflt (
    .pclk_i (pclk), .rst_i (rst), .run_i (run),
    .hsync_o (d_hsync), .vsync_o (d_vsync), .de_o (d_de), .pixel_request_o (d_preq),
    .pixel_x_o (d_px), .pixel_y_o (d_py), .max_x_o (d_max_x), .max_y_o (d_max_y),
    .frame_start_o (d_fs), .frame_done_o (d_fd), .busy_o (d_busy)
  );

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        de;
    logic        req;
    logic [10:0] px;
    logic [10:0] py;
    logic        fs;
    logic        fd;
    logic        busy;
  } obs_t;

  typedef struct {
    int   scen;
    int   cyc;
    bit   dflt;
    obs_t exp;
  } vec_t;

  obs_t obs  [NCyc];
  obs_t dobs [NCyc];
  vec_t vecs [$];

  int n_cmp = 0;
  int n_bad = 0;
  int max_bad, de_n, hs_n, vs_bad, fd_n, fs_n, req_n, align_bad, k;

  function automatic obs_t mk(input logic hs, input logic vs, input logic de_v, input logic req,
                              input int x, input int y, input logic fs_v, input logic fd_v,
                              input logic busy_v);
    obs_t o;
    o.hs = hs; o.vs = vs; o.de = de_v; o.req = req;
    o.px = 11'(x); o.py = 11'(y);
    o.fs = fs_v; o.fd = fd_v; o.busy = busy_v;
    return o;
  endfunction

  function automatic void add(input int scen, input int cyc, input bit dflt, input obs_t e);
    vec_t v;
    v.scen = scen; v.cyc = cyc; v.dflt = dflt; v.exp = e;
    vecs.push_back(v);
  endfunction

  function automatic string fmt(input obs_t o);
    return $sformatf("hs=%b vs=%b de=%b req=%b px=%0d py=%0d fs=%b fd=%b busy=%b",
                     o.hs, o.vs, o.de, o.req, o.px, o.py, o.fs, o.fd, o.busy);
  endfunction

  task automatic check_obs(input string name, input obs_t act, input obs_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got {%s} want {%s}", name, fmt(act), fmt(exp));
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  // Cycle 0 is the first cycle with rst low and run high; obs[c] holds the
  // outputs seen during cycle c. Inputs change right after each sample.
  task automatic run_scen(input int drop_c, input int raise_c, input int rst_c);
    rst = 1'b1;
    run = 1'b0;
    repeat (3) @(posedge pclk);
    #1;
    rst = 1'b0;
    run = 1'b1;
    max_bad = 0;
    obs[0]  = mk(hsync, vsync, de, preq, int'(px), int'(py), fs, fd, busy);
    dobs[0] = mk(d_hsync, d_vsync, d_de, d_preq, int'(d_px), int'(d_py), d_fs, d_fd, d_busy);
    for (int c = 1; c < NCyc; c++) begin
      @(posedge pclk);
      #1;
      obs[c]  = mk(hsync, vsync, de, preq, int'(px), int'(py), fs, fd, busy);
      dobs[c] = mk(d_hsync, d_vsync, d_de, d_preq, int'(d_px), int'(d_py), d_fs, d_fd, d_busy);
      if (max_x !== 11'd4 || max_y !== 11'd3 || d_max_x !== 11'd750 || d_max_y !== 11'd1334)
        max_bad++;
      if (c == drop_c) run = 1'b0;
      if (c == raise_c) run = 1'b1;
      if (c == rst_c) rst = 1'b1;
      else if (c == rst_c + 1) rst = 1'b0;
    end
  endtask

  task automatic apply_table(input int scen);
    foreach (vecs[i]) begin
      if (vecs[i].scen == scen) begin
        check_obs($sformatf("s%0d_%s_c%0d", scen, vecs[i].dflt ? "dflt" : "sim", vecs[i].cyc),
                  vecs[i].dflt ? dobs[vecs[i].cyc] : obs[vecs[i].cyc], vecs[i].exp);
      end
    end
  endtask

  initial begin
    // Sim raster: position index p = c-1, h = p%8, v = p/8. Syncs active-low.
    // Scenario 1: continuous run
    add(1, 0,  0, mk(1, 1, 0, 0, 0, 0, 0, 0, 0));
    add(1, 1,  0, mk(0, 0, 0, 0, 0, 0, 1, 0, 1));
    add(1, 2,  0, mk(1, 0, 0, 0, 0, 0, 0, 0, 1));
    add(1, 9,  0, mk(0, 1, 0, 0, 0, 0, 0, 0, 1));
    add(1, 19, 0, mk(1, 1, 0, 1, 0, 0, 0, 0, 1));
    add(1, 20, 0, mk(1, 1, 1, 1, 1, 0, 0, 0, 1));
    add(1, 22, 0, mk(1, 1, 1, 1, 3, 0, 0, 0, 1));
    add(1, 23, 0, mk(1, 1, 1, 0, 0, 0, 0, 0, 1));
    add(1, 24, 0, mk(1, 1, 0, 0, 0, 0, 0, 0, 1));
    add(1, 29, 0, mk(1, 1, 1, 1, 2, 1, 0, 0, 1));
    add(1, 38, 0, mk(1, 1, 1, 1, 3, 2, 0, 0, 1));
    add(1, 43, 0, mk(1, 1, 0, 0, 0, 0, 0, 0, 1));
    add(1, 48, 0, mk(1, 1, 0, 0, 0, 0, 0, 1, 1));
    add(1, 49, 0, mk(0, 0, 0, 0, 0, 0, 1, 0, 1));
    add(1, 57, 0, mk(0, 1, 0, 0, 0, 0, 0, 0, 1));
    // Default 750x1334 timing: hsync active for h<8, vsync for v<2
    add(1, 1,  1, mk(0, 0, 0, 0, 0, 0, 1, 0, 1));
    add(1, 8,  1, mk(0, 0, 0, 0, 0, 0, 0, 0, 1));
    add(1, 9,  1, mk(1, 0, 0, 0, 0, 0, 0, 0, 1));
    // Scenario 2: run dropped during cycle 30, drain to end of frame
    add(2, 30, 0, mk(1, 1, 1, 1, 3, 1, 0, 0, 1));
    add(2, 40, 0, mk(1, 1, 0, 0, 0, 0, 0, 0, 1));
    add(2, 48, 0, mk(1, 1, 0, 0, 0, 0, 0, 1, 1));
    add(2, 49, 0, mk(1, 1, 0, 0, 0, 0, 0, 0, 0));
    add(2, 55, 0, mk(1, 1, 0, 0, 0, 0, 0, 0, 0));
    // Scenario 3: dropped at 30, re-raised at 35
    add(3, 36, 0, mk(1, 1, 1, 1, 1, 2, 0, 0, 1));
    add(3, 48, 0, mk(1, 1, 0, 0, 0, 0, 0, 1, 1));
    add(3, 49, 0, mk(0, 0, 0, 0, 0, 0, 1, 0, 1));
    add(3, 52, 0, mk(1, 0, 0, 0, 0, 0, 0, 0, 1));
    // Scenario 4: rst high during cycle 22, released during 23 with run high
    add(4, 22, 0, mk(1, 1, 1, 1, 3, 0, 0, 0, 1));
    add(4, 23, 0, mk(1, 1, 0, 0, 0, 0, 0, 0, 0));
    add(4, 24, 0, mk(0, 0, 0, 0, 0, 0, 1, 0, 1));
    add(4, 25, 0, mk(1, 0, 0, 0, 0, 0, 0, 0, 1));
    add(4, 33, 0, mk(1, 1, 0, 0, 0, 0, 0, 0, 1));
    add(4, 48, 0, mk(0, 1, 0, 0, 0, 0, 0, 0, 1));

    run_scen(-1, -1, -1);
    apply_table(1);
    check_int("max_consts", max_bad, 0);

    de_n = 0; hs_n = 0; vs_bad = 0; fd_n = 0; fs_n = 0; req_n = 0;
    for (int c = 1; c <= 48; c++) begin
      if (obs[c].de) de_n++;
      if (obs[c].req) req_n++;
      if (!obs[c].hs) hs_n++;
      if (obs[c].fd) fd_n++;
      if (obs[c].fs) fs_n++;
      if ((obs[c].vs == 1'b0) != (c <= 8)) vs_bad++;
    end
    check_int("de_per_frame", de_n, 12);
    check_int("req_per_frame", req_n, 12);
    check_int("hsync_per_frame", hs_n, 6);
    check_int("vsync_window", vs_bad, 0);
    check_int("frame_done_count", fd_n, 1);
    check_int("frame_start_count", fs_n, 1);

    // Responder registers coordinates on pixel_request; it must line up with de
    align_bad = 0;
    k = 0;
    for (int c = 1; c < NCyc; c++) begin
      if (obs[c].de != obs[c-1].req) align_bad++;
      if (obs[c].de) begin
        if (obs[c-1].px != 11'(k % 4) || obs[c-1].py != 11'(k / 4)) align_bad++;
        k = (k + 1) % 12;
      end
    end
    check_int("req_de_align", align_bad, 0);

    run_scen(30, -1, -1);
    apply_table(2);
    run_scen(30, 35, -1);
    apply_table(3);
    run_scen(-1, -1, 22);
    apply_table(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
